// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter game logic.
// Holds the position width, the ground line, the combat resolver FSM
// state encoding and the default values of the resolver parameters.
package fighter_pkg;

  localparam int POS_W           = 10;
  localparam int PLAYER_GROUND_Y = 360;

  localparam int DEF_NUM_PLAYERS    = 2;
  localparam int DEF_HP_W           = 8;
  localparam int DEF_MAX_HP         = 100;
  localparam int DEF_DAMAGE         = 10;
  localparam int DEF_HITSTUN_FRAMES = 12;
  localparam int DEF_REACH_X        = 48;
  localparam int DEF_REACH_Y        = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TICK  = 3'd1,
    SCAN  = 3'd2,
    APPLY = 3'd3,
    DONE  = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/hit_check.sv
// Geometric hit test for one attacker/defender pair.
// Ports:
//   x_a, y_a      attacker position
//   x_d, y_d      defender position
//   facing_right  attacker facing
//   hit           defender is within reach and in front of the attacker
module hit_check
  import fighter_pkg::*;
#(
  parameter int REACH_X = DEF_REACH_X,
  parameter int REACH_Y = DEF_REACH_Y
) (
  input  logic [POS_W-1:0] x_a,
  input  logic [POS_W-1:0] y_a,
  input  logic [POS_W-1:0] x_d,
  input  logic [POS_W-1:0] y_d,
  input  logic             facing_right,
  output logic             hit
);

  localparam logic [POS_W:0] RX = (POS_W + 1)'(REACH_X);
  localparam logic [POS_W:0] RY = (POS_W + 1)'(REACH_Y);

  logic [POS_W:0] dx;
  logic [POS_W:0] dy;
  logic           in_front;

  always_comb begin
    dx       = (x_d >= x_a) ? ({1'b0, x_d} - {1'b0, x_a}) : ({1'b0, x_a} - {1'b0, x_d});
    dy       = (y_d >= y_a) ? ({1'b0, y_d} - {1'b0, y_a}) : ({1'b0, y_a} - {1'b0, y_d});
    // Equal x counts as "in front" for either facing.
    in_front = facing_right ? (x_d >= x_a) : (x_d <= x_a);
    hit      = in_front && (dx <= RX) && (dy <= RY);
  end

endmodule

// File: rtl/combat_resolver.sv
// Per-frame combat resolution for up to four players.
// On a frame tick the block snapshots positions/attacks, walks every ordered
// (attacker, defender) pair through one shared hit_check, then applies
// damage and hitstun and finally updates ko / round status.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   SCEN                one-cycle frame tick
//   pos_x, pos_y        packed 10-bit positions per player
//   facing_right        per-player facing
//   attack_active       per-player hitbox window
//   health              packed per-player health
//   hitstun_active      per-player hitstun counter nonzero
//   hit_pulse           one cycle per defender hit this frame
//   ko                  per-player health is zero
//   round_over, winner, draw  round status
//   busy                frame resolution in progress
module combat_resolver
  import fighter_pkg::*;
#(
  parameter int NUM_PLAYERS    = DEF_NUM_PLAYERS,
  parameter int HP_W           = DEF_HP_W,
  parameter int MAX_HP         = DEF_MAX_HP,
  parameter int DAMAGE         = DEF_DAMAGE,
  parameter int HITSTUN_FRAMES = DEF_HITSTUN_FRAMES,
  parameter int REACH_X        = DEF_REACH_X,
  parameter int REACH_Y        = DEF_REACH_Y
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          SCEN,
  input  logic [NUM_PLAYERS*POS_W-1:0]  pos_x,
  input  logic [NUM_PLAYERS*POS_W-1:0]  pos_y,
  input  logic [NUM_PLAYERS-1:0]        facing_right,
  input  logic [NUM_PLAYERS-1:0]        attack_active,
  output logic [NUM_PLAYERS*HP_W-1:0]   health,
  output logic [NUM_PLAYERS-1:0]        hitstun_active,
  output logic [NUM_PLAYERS-1:0]        hit_pulse,
  output logic [NUM_PLAYERS-1:0]        ko,
  output logic                          round_over,
  output logic [1:0]                    winner,
  output logic                          draw,
  output logic                          busy
);

  localparam int                IDX_W  = (NUM_PLAYERS > 2) ? 2 : 1;
  localparam int                ST_W   = $clog2(HITSTUN_FRAMES + 1);
  localparam logic [IDX_W-1:0]  LAST_A = IDX_W'(NUM_PLAYERS - 1);
  localparam logic [IDX_W-1:0]  LAST_D = IDX_W'(NUM_PLAYERS - 2);

  fsm_state_t state, state_nxt;

  logic [NUM_PLAYERS-1:0][POS_W-1:0]       snap_x, snap_y;
  logic [NUM_PLAYERS-1:0]                  snap_face, snap_atk, snap_ko, snap_stun_zero;
  logic [NUM_PLAYERS-1:0][NUM_PLAYERS-1:0] hit_latch;
  logic [NUM_PLAYERS-1:0]                  hit_mask;
  logic [NUM_PLAYERS-1:0][ST_W-1:0]        stun, stun_nxt;
  logic [NUM_PLAYERS-1:0][HP_W-1:0]        hp, hp_nxt;
  logic [NUM_PLAYERS-1:0]                  stun_zero, stun_live, ko_nxt;
  logic [IDX_W-1:0]                        a_idx, d_idx, a_nxt, d_nxt;
  logic                                    geo_hit, qualify, last_pair;
  logic [2:0]                              alive_cnt;
  logic [1:0]                              sole;
  int                                      na, nd;

  // FSM state register.
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: each always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (SCEN && !round_over) state_nxt = TICK;
      TICK:    state_nxt = SCAN;
      SCAN:    if (last_pair) state_nxt = APPLY;
      APPLY:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign hit_pulse = (state == APPLY) ? hit_mask : '0;
  assign health    = hp;
  assign last_pair = (a_idx == LAST_A) && (d_idx == LAST_D);

  // Next ordered pair: d ascending within a, skipping d == a.
  always_comb begin
    nd = int'(d_idx) + 1;
    na = int'(a_idx);
    if (nd == na) nd = nd + 1;
    if (nd >= NUM_PLAYERS) begin
      na = na + 1;
      nd = 0;
    end
    a_nxt = IDX_W'(na);
    d_nxt = IDX_W'(nd);
  end

  hit_check #(
    .REACH_X (REACH_X),
    .REACH_Y (REACH_Y)
  ) u_hit_check (
    .x_a          (snap_x[a_idx]),
    .y_a          (snap_y[a_idx]),
    .x_d          (snap_x[d_idx]),
    .y_d          (snap_y[d_idx]),
    .facing_right (snap_face[a_idx]),
    .hit          (geo_hit)
  );

  // A defender already hit this frame is skipped, which gives priority to
  // the lowest-index attacker and keeps its latch untouched.
  assign qualify = snap_atk[a_idx] && !snap_ko[a_idx] && !snap_ko[d_idx] &&
                   snap_stun_zero[d_idx] && !hit_latch[a_idx][d_idx] &&
                   !hit_mask[d_idx] && geo_hit;

  // Counter and health updates for TICK (decrement) and APPLY (damage).
  always_comb begin
    stun_nxt = stun;
    hp_nxt   = hp;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (state == TICK && stun[i] != '0) stun_nxt[i] = stun[i] - 1'b1;
      if (state == APPLY && hit_mask[i]) begin
        stun_nxt[i] = ST_W'(HITSTUN_FRAMES);
        hp_nxt[i]   = (hp[i] > HP_W'(DAMAGE)) ? hp[i] - HP_W'(DAMAGE) : '0;
      end
    end
  end

  // Survivor bookkeeping evaluated from the post-APPLY health.
  always_comb begin
    alive_cnt = '0;
    sole      = '0;
    ko_nxt    = '0;
    stun_zero = '0;
    stun_live = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      ko_nxt[i]    = (hp[i] == '0);
      stun_zero[i] = (stun[i] == '0);
      stun_live[i] = (stun_nxt[i] != '0);
      if (!ko_nxt[i]) begin
        alive_cnt = alive_cnt + 3'd1;
        sole      = 2'(i);
      end
    end
  end

  // NOTE: the frame snapshot is plain datapath that is always rewritten in
  // TICK before SCAN reads it, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == TICK) begin
      snap_x         <= pos_x;
      snap_y         <= pos_y;
      snap_face      <= facing_right;
      snap_atk       <= attack_active;
      snap_ko        <= ko;
      snap_stun_zero <= stun_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) hp[i] <= HP_W'(MAX_HP);
      stun           <= '0;
      hit_latch      <= '0;
      hit_mask       <= '0;
      hitstun_active <= '0;
      ko             <= '0;
      round_over     <= 1'b0;
      winner         <= '0;
      draw           <= 1'b0;
      a_idx          <= '0;
      d_idx          <= '0;
    end else begin
      stun <= stun_nxt;
      hp   <= hp_nxt;
      case (state)
        TICK: begin
          hit_mask       <= '0;
          a_idx          <= '0;
          d_idx          <= IDX_W'(1);
          hitstun_active <= stun_live;
          for (int a = 0; a < NUM_PLAYERS; a++)
            if (!attack_active[a]) hit_latch[a] <= '0;
        end
        SCAN: begin
          if (qualify) begin
            hit_mask[d_idx]         <= 1'b1;
            hit_latch[a_idx][d_idx] <= 1'b1;
          end
          a_idx <= a_nxt;
          d_idx <= d_nxt;
        end
        APPLY: hitstun_active <= stun_live;
        DONE: begin
          ko         <= ko_nxt;
          round_over <= (alive_cnt <= 3'd1);
          winner     <= (alive_cnt == 3'd1) ? sole : 2'd0;
          draw       <= (alive_cnt == 3'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/combat_resolver.md
COMBAT_RESOLVER -- requirements
Module: combat_resolver

Interface
REQ-001 Parameters, each given as name, default and meaning:
- NUM_PLAYERS, 2, number of player channels (legal 2..4).
- HP_W, 8, health width.
- MAX_HP, 100, health loaded at reset.
- DAMAGE, 10, health removed per landed hit.
- HITSTUN_FRAMES, 12, frames of hitstun per landed hit.
- REACH_X, 48, max horizontal distance for a hit.
- REACH_Y, 32, max vertical distance for a hit.

REQ-002 Ports, each given as name, direction, width and meaning:
- clk, in, 1, pixel clock; the only clock.
- reset, in, 1, synchronous, active-high.
- SCEN, in, 1, one-cycle frame tick.
- pos_x, in, NUM_PLAYERS*10, packed x per player; player i is bits [10i+9:10i].
- pos_y, in, NUM_PLAYERS*10, packed y per player; same packing.
- facing_right, in, NUM_PLAYERS, per player.
- attack_active, in, NUM_PLAYERS, hitbox window per player.
- health, out, NUM_PLAYERS*HP_W, packed.
- hitstun_active, out, NUM_PLAYERS, hitstun counter nonzero.
- hit_pulse, out, NUM_PLAYERS, one-cycle flag: defender took a hit.
- ko, out, NUM_PLAYERS, health equals 0.
- round_over, out, 1, at most one player alive.
- winner, out, 2, index of the survivor.
- draw, out, 1, round over with no survivor.
- busy, out, 1, resolution in progress.

Function
REQ-003 FSM states are IDLE, TICK, SCAN, APPLY and DONE.
REQ-004 IDLE: on SCEN with round_over=0, go to TICK. SCEN in any other state, or with round_over=1, is ignored.
REQ-005 TICK (1 cycle):
- Snapshot pos_x, pos_y, facing_right, attack_active, hitstun counters and ko.
- Decrement every nonzero hitstun counter by 1.
REQ-006 SCAN visits one ordered pair (a,d) per cycle, a!=d, in the order a ascending then d ascending. It takes NUM_PLAYERS*(NUM_PLAYERS-1) cycles.
REQ-007 A pair hits when all of the following hold in the snapshot:
- attack_active[a] is set.
- ko[a]=0 and ko[d]=0.
- The defender's snapshot hitstun is 0.
- latch[a][d]=0.
- |x_d-x_a|<=REACH_X and |y_d-y_a|<=REACH_Y, using 11-bit unsigned difference magnitudes.
- The attacker faces the defender: facing_right=1 requires x_d>=x_a; facing_right=0 requires x_d<=x_a.
REQ-008 Each defender takes at most one hit per frame, from the lowest-index qualifying attacker. Later qualifying pairs on an already-hit defender are skipped and do not set a latch.
REQ-009 A qualifying hit sets latch[a][d]. latch[a][*] clears in TICK whenever snapshot attack_active[a]=0, so one attack window lands on a given defender at most once.
REQ-010 Mutual hits in the same frame (a hits d and d hits a) both land, because the decision uses snapshot state only.
REQ-011 APPLY (1 cycle), for each player hit this frame:
- health becomes max(health-DAMAGE, 0), a saturating subtract that never wraps.
- The hitstun counter loads HITSTUN_FRAMES.
- hit_pulse is asserted for this cycle only.
REQ-012 DONE (1 cycle):
- ko[i] = (health[i]==0).
- round_over=1 when the count of non-ko players is <=1.
- winner = the index of the sole survivor, otherwise 0.
- draw=1 when the survivor count is 0.
- Then return to IDLE.
REQ-013 Latency: outputs are final 3+NUM_PLAYERS*(NUM_PLAYERS-1) cycles after SCEN. That is 5 cycles for N=2 and 15 cycles for N=4.
REQ-014 busy=1 in every state except IDLE.
REQ-015 hitstun_active[i] is a registered copy of (counter[i]!=0), updated in TICK and APPLY.
REQ-016 Once round_over=1:
- health, ko, winner and draw hold.
- Hitstun counters stop decrementing.
- The block leaves this condition only on reset.

Reset
REQ-017 On reset=1 at a clk edge, in any state:
- FSM goes to IDLE.
- Every health = MAX_HP.
- Hitstun counters, latches, hit_pulse, ko, round_over, winner, draw and busy = 0.
REQ-018 Reset mid-SCAN discards that frame's hits. No partial damage is applied.

Structure
REQ-019 Shared package fighter_pkg holds:
- POS_W=10.
- PLAYER_GROUND_Y=360.
- FSM state encodings.
- Parameter defaults.
REQ-020 The pair test of REQ-007 is one combinational sub-module, hit_check. Its inputs are two positions, the attacker's facing and the reach parameters; its output is a hit flag. It is instantiated once and time-shared by SCAN.

Verification
REQ-021 N=2, P0 x=100 facing right, P1 x=140, same y, attack_active[0] high for 7 frames:
- Exactly one hit lands: health[1]=90.
- hit_pulse[1] pulses once.
- hitstun_active[1] stays high for 12 frames.
REQ-022 P1 x=149 (distance 49), otherwise as REQ-021 -> no hit; health stays 100.
REQ-023 P0 facing left, P1 at x=140 -> no hit. With P1 at x=60 -> hit.
REQ-024 Both players attack facing each other at distance 30 in the same frame -> both health=90 and both hit_pulse asserted in the same cycle.
REQ-025 Set MAX_HP=20 and land two separate attacks on P1:
- After the second hit, health[1]=0, ko[1]=1, round_over=1, winner=0, draw=0.
- Further SCEN changes nothing.
REQ-026 N=4, players 0 and 2 both in range of player 1 and attacking:
- Only player 0's hit lands; health[1]=90.
- busy lasts 15 cycles.
- Asserting reset during SCAN restores all health to 100.
